// File: rtl/ebi_multichan.sv
// EBI slave: command assembly into the command FIFO, one-word prefetch per sample channel,
// coherent timestamp reads, saturating drop counter and a maskable sticky interrupt.
module ebi_multichan #(
  parameter int DATA_W    = 16,
  parameter int CMD_WORDS = 5,
  parameter int N_CH      = 4,
  parameter int CNT_W     = 16,
  parameter int TIME_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         data_in,
  output logic [DATA_W-1:0]         data_out,
  input  logic [18:0]               addr,
  input  logic                      rd,
  input  logic                      wr,
  input  logic                      cs,
  output logic [CMD_WORDS*DATA_W-1:0] cmd_fifo_data_in,
  output logic                      cmd_fifo_wr_en,
  input  logic                      cmd_fifo_full,
  input  logic [N_CH*DATA_W-1:0]    sample_fifo_data_out,
  output logic [N_CH-1:0]           sample_fifo_rd_en,
  input  logic [N_CH-1:0]           sample_fifo_empty,
  input  logic [N_CH-1:0]           sample_fifo_full,
  input  logic [N_CH*CNT_W-1:0]     sample_fifo_data_count,
  input  logic [TIME_W-1:0]         time_in,
  output logic                      irq
);

  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int ST_W  = N_CH + 1;
  localparam int HI_W  = TIME_W - DATA_W;

  localparam logic [7:0] A_STATUS = 8'h00;
  localparam logic [7:0] A_MASK   = 8'h10;
  localparam logic [7:0] A_ISTAT  = 8'h11;
  localparam logic [7:0] A_SEL    = 8'h12;
  localparam logic [7:0] A_SAMPLE = 8'h13;
  localparam logic [7:0] A_COUNT  = 8'h14;
  localparam logic [7:0] A_TLO    = 8'h15;
  localparam logic [7:0] A_THI    = 8'h16;
  localparam logic [7:0] A_DROP   = 8'h17;

  localparam logic [0:0] CMD_IDLE  = 1'b0;
  localparam logic [0:0] CMD_ARMED = 1'b1;

  localparam logic [1:0] PF_EMPTY = 2'd0;
  localparam logic [1:0] PF_POP   = 2'd1;
  localparam logic [1:0] PF_HOLD  = 2'd2;

  logic [7:0] a8;
  logic       unused_addr;
  logic       rd_act, wr_act, rd_done, wr_done;

  assign a8          = addr[7:0];
  assign unused_addr = ^addr[18:8];
  assign rd_act      = cs & rd;
  assign wr_act      = cs & wr;

  logic              rd_s1_q, rd_s1_d, rd_s2_q, rd_s2_d;
  logic              wr_s1_q, wr_s1_d, wr_s2_q, wr_s2_d;
  logic [7:0]        rd_addr_q, rd_addr_d;
  logic [SEL_W-1:0]  rd_sel_q, rd_sel_d;
  logic              rd_hit_q, rd_hit_d;
  logic [DATA_W-1:0] cmd_q [CMD_WORDS];
  logic [DATA_W-1:0] cmd_d [CMD_WORDS];
  logic [ST_W-1:0]   mask_q, mask_d;
  logic [ST_W-1:0]   sticky_q, sticky_d;
  logic [ST_W-1:0]   snap_q, snap_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] drop_q, drop_d;
  logic [HI_W-1:0]   time_cap_q, time_cap_d;
  logic [HI_W-1:0]   time_hi_q, time_hi_d;
  logic [N_CH-1:0]   full_prev_q, full_prev_d;
  logic [0:0]        cmd_st_q, cmd_st_d;
  logic [1:0]        pf_q [N_CH];
  logic [1:0]        pf_d [N_CH];
  logic [DATA_W-1:0] hold_q [N_CH];
  logic [DATA_W-1:0] hold_d [N_CH];
  logic [N_CH-1:0]   valid_q, valid_d;
  logic              live_q, live_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              irq_q, irq_d;

  logic              sel_ok;
  logic              drop_evt;
  logic [ST_W-1:0]   sticky_set;
  logic [DATA_W-1:0] status;
  logic [DATA_W-1:0] rd_val;

  assign rd_done = rd_s2_q & ~rd_s1_q;
  assign wr_done = wr_s2_q & ~wr_s1_q;
  assign sel_ok  = (int'(sel_q) < N_CH);

  assign data_out = dout_q;
  assign irq      = irq_q;

  always_comb begin
    cmd_fifo_data_in = '0;
    for (int i = 0; i < CMD_WORDS; i++) begin
      cmd_fifo_data_in[(CMD_WORDS-i)*DATA_W-1 -: DATA_W] = cmd_q[i];
    end
  end

  always_comb begin
    status = '0;
    status[DATA_W-1]        = cmd_fifo_full;
    status[DATA_W-2]        = |sample_fifo_full;
    status[DATA_W-3]        = |sample_fifo_empty;
    status[DATA_W-4 -: N_CH] = valid_q;
  end

  always_comb begin
    rd_val = '0;
    case (a8)
      A_STATUS: rd_val = status;
      A_MASK:   rd_val = DATA_W'(mask_q);
      A_ISTAT:  rd_val = DATA_W'(sticky_q);
      A_SEL:    rd_val = DATA_W'(sel_q);
      A_SAMPLE: rd_val = (sel_ok && valid_q[sel_q]) ? hold_q[sel_q] : DATA_W'(16'hDEAD);
      A_COUNT:  rd_val = sel_ok ? DATA_W'(sample_fifo_data_count[int'(sel_q)*CNT_W +: CNT_W]) : '0;
      A_TLO:    rd_val = time_in[DATA_W-1:0];
      A_THI:    rd_val = DATA_W'(time_hi_q);
      A_DROP:   rd_val = drop_q;
      default: begin
        for (int i = 0; i < CMD_WORDS; i++) begin
          if (a8 == 8'(i + 1)) rd_val = cmd_q[i];
        end
      end
    endcase
  end

  // Bus-side registers, strobe pipeline and command FSM.
  always_comb begin
    rd_s1_d     = rd_act;
    rd_s2_d     = rd_s1_q;
    wr_s1_d     = wr_act;
    wr_s2_d     = wr_s1_q;
    rd_addr_d   = rd_addr_q;
    rd_sel_d    = rd_sel_q;
    rd_hit_d    = rd_hit_q;
    mask_d      = mask_q;
    sel_d       = sel_q;
    snap_d      = snap_q;
    time_cap_d  = time_cap_q;
    time_hi_d   = time_hi_q;
    dout_d      = dout_q;
    drop_d      = drop_q;
    cmd_st_d    = cmd_st_q;
    live_d      = 1'b1;
    full_prev_d = sample_fifo_full;
    drop_evt    = 1'b0;
    cmd_fifo_wr_en = 1'b0;
    for (int i = 0; i < CMD_WORDS; i++) cmd_d[i] = cmd_q[i];

    if (wr_act) begin
      case (a8)
        A_MASK: mask_d = data_in[ST_W-1:0];
        A_SEL:  sel_d  = data_in[SEL_W-1:0];
        default: begin
          for (int i = 0; i < CMD_WORDS; i++) begin
            if (a8 == 8'(i + 1)) cmd_d[i] = data_in;
          end
        end
      endcase
    end

    // Snapshot what the host actually saw so the completion acts on the returned value.
    if (rd_act) begin
      dout_d    = rd_val;
      rd_addr_d = a8;
      rd_sel_d  = sel_q;
      rd_hit_d  = sel_ok && valid_q[sel_q];
      if (a8 == A_ISTAT) snap_d = sticky_q;
      if (a8 == A_TLO)   time_cap_d = time_in[TIME_W-1:DATA_W];
    end

    if (rd_done && rd_addr_q == A_TLO) time_hi_d = time_cap_q;

    case (cmd_st_q)
      CMD_IDLE: begin
        if (wr_act && a8 == 8'(CMD_WORDS)) cmd_st_d = CMD_ARMED;
      end
      default: begin
        if (wr_done) begin
          cmd_st_d = CMD_IDLE;
          if (!cmd_fifo_full) cmd_fifo_wr_en = 1'b1;
          else                drop_evt       = 1'b1;
        end
      end
    endcase

    if (drop_evt && drop_q != '1) drop_d = drop_q + 1'b1;
  end

  // Sticky status: a set in the clearing cycle survives the clear.
  always_comb begin
    sticky_set = {sample_fifo_full & ~full_prev_q, drop_evt};
    sticky_d   = sticky_q;
    if (rd_done && rd_addr_q == A_ISTAT) sticky_d = sticky_d & ~snap_q;
    sticky_d = sticky_d | sticky_set;
    irq_d    = |(sticky_d & mask_q);
  end

  always_comb begin
    sample_fifo_rd_en = '0;
    valid_d           = valid_q;
    for (int c = 0; c < N_CH; c++) begin
      pf_d[c]   = pf_q[c];
      hold_d[c] = hold_q[c];
      case (pf_q[c])
        PF_EMPTY: begin
          if (live_q && !sample_fifo_empty[c]) begin
            sample_fifo_rd_en[c] = 1'b1;
            pf_d[c] = PF_POP;
          end
        end
        PF_POP: begin
          hold_d[c]  = sample_fifo_data_out[c*DATA_W +: DATA_W];
          valid_d[c] = 1'b1;
          pf_d[c]    = PF_HOLD;
        end
        default: begin
          if (rd_done && rd_addr_q == A_SAMPLE && rd_hit_q && int'(rd_sel_q) == c) begin
            valid_d[c] = 1'b0;
            pf_d[c]    = PF_EMPTY;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_s1_q     <= 1'b0;
      rd_s2_q     <= 1'b0;
      wr_s1_q     <= 1'b0;
      wr_s2_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_sel_q    <= '0;
      rd_hit_q    <= 1'b0;
      mask_q      <= '0;
      sticky_q    <= '0;
      snap_q      <= '0;
      sel_q       <= '0;
      drop_q      <= '0;
      time_cap_q  <= '0;
      time_hi_q   <= '0;
      full_prev_q <= '0;
      cmd_st_q    <= CMD_IDLE;
      valid_q     <= '0;
      live_q      <= 1'b0;
      dout_q      <= '0;
      irq_q       <= 1'b0;
      for (int i = 0; i < CMD_WORDS; i++) cmd_q[i] <= '0;
      for (int c = 0; c < N_CH; c++) begin
        pf_q[c]   <= PF_EMPTY;
        hold_q[c] <= '0;
      end
    end else begin
      rd_s1_q     <= rd_s1_d;
      rd_s2_q     <= rd_s2_d;
      wr_s1_q     <= wr_s1_d;
      wr_s2_q     <= wr_s2_d;
      rd_addr_q   <= rd_addr_d;
      rd_sel_q    <= rd_sel_d;
      rd_hit_q    <= rd_hit_d;
      mask_q      <= mask_d;
      sticky_q    <= sticky_d;
      snap_q      <= snap_d;
      sel_q       <= sel_d;
      drop_q      <= drop_d;
      time_cap_q  <= time_cap_d;
      time_hi_q   <= time_hi_d;
      full_prev_q <= full_prev_d;
      cmd_st_q    <= cmd_st_d;
      valid_q     <= valid_d;
      live_q      <= live_d;
      dout_q      <= dout_d;
      irq_q       <= irq_d;
      for (int i = 0; i < CMD_WORDS; i++) cmd_q[i] <= cmd_d[i];
      for (int c = 0; c < N_CH; c++) begin
        pf_q[c]   <= pf_d[c];
        hold_q[c] <= hold_d[c];
      end
    end
  end

endmodule

// File: tb/tb_ebi_multichan.sv
// Directed bench for ebi_multichan: register table, command push/drop, prefetch, time, irq, reset.
module tb_ebi_multichan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic [18:0] addr = '0;
  logic        rd = 1'b0, wr = 1'b0, cs = 1'b0;
  logic [79:0] cmd_fifo_data_in;
  logic        cmd_fifo_wr_en;
  logic        cmd_fifo_full = 1'b0;
  logic [63:0] sample_fifo_data_out;
  logic [3:0]  sample_fifo_rd_en;
  logic [3:0]  sample_fifo_empty;
  logic [3:0]  sample_fifo_full = '0;
  logic [63:0] sample_fifo_data_count;
  logic [31:0] time_in = '0;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign sample_fifo_data_count = {16'h0103, 16'h0102, 16'h0101, 16'h0100};

  ebi_multichan dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_out(data_out), .addr(addr),
    .rd(rd), .wr(wr), .cs(cs),
    .cmd_fifo_data_in(cmd_fifo_data_in), .cmd_fifo_wr_en(cmd_fifo_wr_en),
    .cmd_fifo_full(cmd_fifo_full),
    .sample_fifo_data_out(sample_fifo_data_out), .sample_fifo_rd_en(sample_fifo_rd_en),
    .sample_fifo_empty(sample_fifo_empty), .sample_fifo_full(sample_fifo_full),
    .sample_fifo_data_count(sample_fifo_data_count), .time_in(time_in), .irq(irq)
  );

  // Sample FIFO model: registered read data, pop on rd_en when non-empty.
  logic [3:0]  push_req = '0;
  logic [15:0] push_val = '0;
  logic [15:0] fmem [4][8];
  int          fhead [4] = '{default: 0};
  int          ftail [4] = '{default: 0};
  logic [15:0] fdout [4] = '{default: 16'h0};

  always @(posedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (push_req[c]) begin
        fmem[c][ftail[c] % 8] <= push_val;
        ftail[c] <= ftail[c] + 1;
      end
      if (sample_fifo_rd_en[c] && fhead[c] != ftail[c]) begin
        fdout[c] <= fmem[c][fhead[c] % 8];
        fhead[c] <= fhead[c] + 1;
      end
    end
  end

  always_comb begin
    sample_fifo_empty    = '0;
    sample_fifo_data_out = '0;
    for (int c = 0; c < 4; c++) begin
      sample_fifo_empty[c] = (fhead[c] == ftail[c]);
      sample_fifo_data_out[c*16 +: 16] = fdout[c];
    end
  end

  int          wr_cnt = 0;
  int          rd_cnt [4] = '{default: 0};
  logic [79:0] cmd_cap = '0;

  always @(negedge clk) begin
    if (cmd_fifo_wr_en) begin
      wr_cnt  <= wr_cnt + 1;
      cmd_cap <= cmd_fifo_data_in;
    end
    for (int c = 0; c < 4; c++) begin
      if (sample_fifo_rd_en[c]) rd_cnt[c] <= rd_cnt[c] + 1;
    end
  end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = {11'h155, a}; data_in = d; cs = 1'b1; wr = 1'b1;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [15:0] d);
    @(negedge clk);
    addr = {11'h155, a}; cs = 1'b1; rd = 1'b1;
    @(negedge clk);
    @(negedge clk);
    d = data_out;
    cs = 1'b0; rd = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  typedef struct {
    logic        do_wr;
    logic [7:0]  a;
    logic [15:0] wd;
    logic [15:0] exp;
  } vec_t;

  vec_t vt [13];

  initial begin
    logic [15:0] rv;
    int          w0, r0, r2;
    bit          found;

    vt[0]  = '{1'b1, 8'h01, 16'h1111, 16'h1111};
    vt[1]  = '{1'b1, 8'h02, 16'h2222, 16'h2222};
    vt[2]  = '{1'b1, 8'h03, 16'h3333, 16'h3333};
    vt[3]  = '{1'b1, 8'h04, 16'h4444, 16'h4444};
    vt[4]  = '{1'b1, 8'h05, 16'h5555, 16'h5555};
    vt[5]  = '{1'b1, 8'h10, 16'hFFFF, 16'h001F};
    vt[6]  = '{1'b1, 8'h10, 16'h0000, 16'h0000};
    vt[7]  = '{1'b1, 8'h12, 16'h0006, 16'h0002};
    vt[8]  = '{1'b0, 8'h14, 16'h0000, 16'h0102};
    vt[9]  = '{1'b1, 8'h20, 16'hBEEF, 16'h0000};
    vt[10] = '{1'b0, 8'h06, 16'h0000, 16'h0000};
    vt[11] = '{1'b0, 8'h00, 16'h0000, 16'h2200};
    vt[12] = '{1'b0, 8'h17, 16'h0000, 16'h0000};

    // Reset state, with channel 0 preloaded while the DUT is held in reset.
    @(negedge clk);
    push_req = 4'b0001; push_val = 16'h00C0;
    @(negedge clk);
    push_req = '0;
    @(negedge clk);
    check("rst_data_out", 80'(data_out), 80'h0);
    check("rst_irq", 80'(irq), 80'h0);
    check("rst_wr_en", 80'(cmd_fifo_wr_en), 80'h0);
    check("rst_rd_en", 80'(sample_fifo_rd_en), 80'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      if (vt[i].do_wr) bus_write(vt[i].a, vt[i].wd);
      bus_read(vt[i].a, rv);
      check($sformatf("vec%0d_addr%02h", i, vt[i].a), 80'(rv), 80'(vt[i].exp));
    end
    check("cmd_push_count", 80'(wr_cnt), 80'd1);
    check("cmd_push_data", cmd_cap, 80'h1111_2222_3333_4444_5555);

    // Command drops while the FIFO is full.
    cmd_fifo_full = 1'b1;
    w0 = wr_cnt;
    for (int k = 0; k < 2; k++) begin
      for (int j = 1; j <= 5; j++) bus_write(8'(j), 16'(j * 16'h1111));
    end
    check("drop_no_push", 80'(wr_cnt - w0), 80'd0);
    bus_read(8'h17, rv);
    check("drop_count", 80'(rv), 80'd2);
    bus_write(8'h10, 16'h0001);
    check("drop_irq", 80'(irq), 80'd1);
    bus_read(8'h11, rv);
    check("istat_drop", 80'(rv), 80'h0001);
    bus_read(8'h11, rv);
    check("istat_cleared", 80'(rv), 80'h0000);
    check("irq_cleared", 80'(irq), 80'd0);
    cmd_fifo_full = 1'b0;

    // Channel 2 prefetch with sel=2 from the table.
    r0 = rd_cnt[0];
    r2 = rd_cnt[2];
    @(negedge clk);
    push_req = 4'b0100; push_val = 16'h00A0;
    @(negedge clk);
    push_val = 16'h00A1;
    @(negedge clk);
    push_req = '0;
    repeat (6) @(negedge clk);
    bus_read(8'h00, rv);
    check("status_ch0_ch2_valid", 80'(rv), 80'h2A00);
    bus_read(8'h13, rv);
    check("ch2_read0", 80'(rv), 80'h00A0);
    bus_read(8'h13, rv);
    check("ch2_read1", 80'(rv), 80'h00A1);
    bus_read(8'h13, rv);
    check("ch2_read_dead", 80'(rv), 80'hDEAD);
    repeat (4) @(negedge clk);
    check("ch2_pop_count", 80'(rd_cnt[2] - r2), 80'd2);
    check("ch0_no_pop", 80'(rd_cnt[0] - r0), 80'd0);
    bus_read(8'h00, rv);
    check("status_ch0_still_valid", 80'(rv), 80'h2200);

    // Coherent timestamp.
    time_in = 32'h0001_FFFF;
    bus_read(8'h15, rv);
    check("time_lo", 80'(rv), 80'hFFFF);
    time_in = 32'h0002_0000;
    bus_read(8'h16, rv);
    check("time_hi_latched", 80'(rv), 80'h0001);

    // Full[3] edge coinciding with the clearing completion of an irq status read.
    bus_write(8'h10, 16'h0010);
    @(negedge clk);
    sample_fifo_full[3] = 1'b1;
    @(negedge clk);
    sample_fifo_full[3] = 1'b0;
    repeat (3) @(negedge clk);
    check("irq_full3", 80'(irq), 80'd1);
    @(negedge clk);
    addr = {11'h155, 8'h11}; cs = 1'b1; rd = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rv = data_out;
    cs = 1'b0; rd = 1'b0;
    @(negedge clk);
    sample_fifo_full[3] = 1'b1;
    repeat (6) @(negedge clk);
    check("istat_full3", 80'(rv), 80'h0010);
    check("irq_set_wins", 80'(irq), 80'd1);
    bus_read(8'h11, rv);
    check("istat_full3_kept", 80'(rv), 80'h0010);
    check("irq_cleared2", 80'(irq), 80'd0);

    // Asynchronous reset while ARMED and while channel 1 is in POP.
    @(negedge clk);
    addr = {11'h155, 8'h05}; data_in = 16'h5555; cs = 1'b1; wr = 1'b1;
    push_req = 4'b0010; push_val = 16'h00B0;
    @(negedge clk);
    push_val = 16'h00B1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (sample_fifo_rd_en[1]) found = 1'b1;
      else @(negedge clk);
    end
    check("ch1_first_pop_seen", 80'(found), 80'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    push_req = '0;
    #1;
    check("arst_data_out", 80'(data_out), 80'h0);
    check("arst_wr_en", 80'(cmd_fifo_wr_en), 80'h0);
    check("arst_rd_en", 80'(sample_fifo_rd_en), 80'h0);
    check("arst_irq", 80'(irq), 80'h0);
    cs = 1'b0; wr = 1'b0;
    sample_fifo_full[3] = 1'b0;
    repeat (3) @(negedge clk);
    w0 = wr_cnt;
    r0 = rd_cnt[1];
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("arst_no_push", 80'(wr_cnt - w0), 80'd0);
    check("arst_repop", 80'(rd_cnt[1] - r0), 80'd1);
    bus_write(8'h12, 16'h0001);
    bus_read(8'h13, rv);
    check("arst_ch1_second_word", 80'(rv), 80'h00B1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
    $fatal(1);
  end

endmodule
